branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 119 +++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// One-cycle registered lookup; updates from Execute are always accepted.
module branch_target_buffer #(
   parameter int unsigned ENTRIES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] lookupAddress,
   input  logic        lookupValid,
   input  logic        lookupHold,
   input  logic        updateValid,
   input  logic [31:0] updateAddress,
   input  logic [31:0] updateTarget,
   input  logic        updateTaken,
   output logic [31:0] branchPredictData,
   output logic        branchPredictValid
);

   localparam int unsigned IdxW = $clog2(ENTRIES);
   localparam int unsigned TagW = 30 - IdxW;

   typedef logic [IdxW-1:0] idx_t;
   typedef logic [TagW-1:0] tag_t;

   logic [ENTRIES-1:0] valid_q;
   logic [1:0]         cnt_q    [ENTRIES];
   tag_t               tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];

   idx_t        l_idx, u_idx;
   tag_t        l_tag, u_tag;
   logic        l_hit, u_hit;
   logic        cnt_we, tgt_we, alloc;
   logic [1:0]  cnt_d;
   logic        pred_valid_d, pred_valid_q;
   logic [31:0] pred_data_d, pred_data_q;

   // Byte-offset bits never participate in index or tag.
   logic unused_offset;
   assign unused_offset = ^{lookupAddress[1:0], updateAddress[1:0]};

   assign l_idx = lookupAddress[IdxW+1:2];
   assign l_tag = lookupAddress[31:IdxW+2];
   assign u_idx = updateAddress[IdxW+1:2];
   assign u_tag = updateAddress[31:IdxW+2];

   assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   always_comb begin
      pred_valid_d = lookupValid && l_hit && cnt_q[l_idx][1];
      pred_data_d  = pred_valid_d ? target_q[l_idx] : 32'h0;
   end

   always_comb begin
      cnt_d  = cnt_q[u_idx];
      cnt_we = 1'b0;
      tgt_we = 1'b0;
      alloc  = 1'b0;
      if (updateValid) begin
         if (u_hit) begin
            cnt_we = 1'b1;
            if (updateTaken) begin
               tgt_we = 1'b1;
               cnt_d  = (cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'b01;
            end else begin
               cnt_d  = (cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'b01;
            end
         end else if (updateTaken) begin
            alloc  = 1'b1;
            cnt_we = 1'b1;
            tgt_we = 1'b1;
            cnt_d  = 2'b10;
         end
      end
   end

   // Table state is written at the edge, so a same-cycle lookup reads the old entry.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= 2'b01;
         end
      end else begin
         if (alloc) begin
            valid_q[u_idx] <= 1'b1;
         end
         if (cnt_we) begin
            cnt_q[u_idx] <= cnt_d;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         if (alloc) begin
            tag_q[u_idx] <= u_tag;
         end
         if (tgt_we) begin
            target_q[u_idx] <= updateTarget;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pred_valid_q <= 1'b0;
         pred_data_q  <= 32'h0;
      end else if (!lookupHold) begin
         pred_valid_q <= pred_valid_d;
         pred_data_q  <= pred_data_d;
      end
   end

   assign branchPredictValid = pred_valid_q;
   assign branchPredictData  = pred_data_q;

endmodule
